// File: rtl/regfile_pkg.sv
// Shared constants, types and helpers for the 2-read/1-write register file.
package regfile_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 32;

  typedef logic [DEFAULT_WIDTH-1:0]         word_t;
  typedef logic [$clog2(DEFAULT_DEPTH)-1:0] addr_t;

  function automatic int addr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Word 0 is read-only when the zero register is enabled; addresses past DEPTH do not exist.
  function automatic logic addr_writable(input int unsigned addr, input int unsigned depth,
                                         input int unsigned zero_reg);
    return (addr < depth) && !((zero_reg != 0) && (addr == 0));
  endfunction

endpackage

// File: rtl/regfile_if.sv
// Bus bundle between a register-file client (master) and the register file (slave).
interface regfile_if import regfile_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
);
  localparam int AW = addr_bits(DEPTH);

  // Handshake: re/we are sampled on every rising edge with no backpressure; rvalid is a
  // one-cycle pulse meaning rd1/rd2 hold the data for the read sampled at the previous edge.
  logic             we;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;
  logic             re;
  logic [AW-1:0]    ra1;
  logic [AW-1:0]    ra2;
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;
  logic             rvalid;

  modport master (
    output we, waddr, wdata, re, ra1, ra2,
    input  rd1, rd2, rvalid
  );

  modport slave (
    input  we, waddr, wdata, re, ra1, ra2,
    output rd1, rd2, rvalid
  );

endinterface

// File: rtl/regfile_word.sv
// One storage word: write-enabled register with asynchronous active-low clear.
module regfile_word #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_we,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_we) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/regfile_2r1w.sv
// Register file with two registered read ports and one write port.
// Define REGFILE_BYPASS_EN to forward same-edge write data onto a matching read port.
module regfile_2r1w import regfile_pkg::*; #(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int ZERO_REG = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  regfile_if.slave  bus
);

  localparam int AW = addr_bits(DEPTH);

  logic [WIDTH-1:0] w_words [DEPTH];
  logic             w_wr_ok;
  logic [WIDTH-1:0] w_rd1;
  logic [WIDTH-1:0] w_rd2;
  logic [WIDTH-1:0] r_rd1;
  logic [WIDTH-1:0] r_rd2;
  logic             r_rvalid;

  assign w_wr_ok = bus.we && addr_writable(32'(bus.waddr), DEPTH, ZERO_REG);

  for (genvar g = 0; g < DEPTH; g++) begin : g_word
    if ((ZERO_REG != 0) && (g == 0)) begin : g_zero
      assign w_words[g] = '0;
    end else begin : g_store
      logic w_we;
      assign w_we = w_wr_ok && (bus.waddr == AW'(g));
      regfile_word #(.WIDTH(WIDTH)) u_word (
        .clk   (clk),
        .rst_n (rst_n),
        .i_we  (w_we),
        .i_d   (bus.wdata),
        .o_q   (w_words[g])
      );
    end
  end

  // Unmatched (out-of-range) addresses fall through to zero.
  always_comb begin
    w_rd1 = '0;
    w_rd2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.ra1 == AW'(i)) w_rd1 = w_words[i];
      if (bus.ra2 == AW'(i)) w_rd2 = w_words[i];
    end
`ifdef REGFILE_BYPASS_EN
    if (w_wr_ok && (bus.waddr == bus.ra1)) w_rd1 = bus.wdata;
    if (w_wr_ok && (bus.waddr == bus.ra2)) w_rd2 = bus.wdata;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd1    <= '0;
      r_rd2    <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= bus.re;
      if (bus.re) begin
        r_rd1 <= w_rd1;
        r_rd2 <= w_rd2;
      end
    end
  end

  assign bus.rd1    = r_rd1;
  assign bus.rd2    = r_rd2;
  assign bus.rvalid = r_rvalid;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Self-checking bench for regfile_2r1w: default 32x32 zero-reg instance plus an 8x4 instance.
module tb_regfile_2r1w;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  regfile_if #(.WIDTH(32), .DEPTH(32)) bus ();
  regfile_if #(.WIDTH(8),  .DEPTH(4))  s_bus ();

  regfile_2r1w #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  regfile_2r1w #(.WIDTH(8), .DEPTH(4), .ZERO_REG(0)) u_small (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (s_bus)
  );

  int          total = 0;
  int          bad   = 0;
  logic [63:0] exp_q[$];
  logic [31:0] mdl [32];
  logic [31:0] hold1;
  logic [31:0] hold2;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    hold1 = '0;
    hold2 = '0;
    exp_q.delete();
  endtask

  function automatic logic [31:0] mread(input logic [4:0] a, input logic we,
                                        input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
    if (we && (wa == a)) return wd;
`endif
    return mdl[a];
  endfunction

  // One clock of the main port: drive, predict, advance one edge, then check.
  task automatic cycle(input string tag, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic re,
                       input logic [4:0] a1, input logic [4:0] a2);
    logic [63:0] e;
    bus.we = we; bus.waddr = wa; bus.wdata = wd;
    bus.re = re; bus.ra1 = a1; bus.ra2 = a2;
    if (re) exp_q.push_back({mread(a1, we, wa, wd), mread(a2, we, wa, wd)});
    if (we && (wa != 5'd0)) mdl[wa] = wd;
    @(posedge clk);
    #1;
    if (re) begin
      e = exp_q.pop_front();
      hold1 = e[63:32];
      hold2 = e[31:0];
    end
    chk({tag, ".rvalid"}, 64'(bus.rvalid), 64'(re));
    chk({tag, ".rd"}, {bus.rd1, bus.rd2}, {hold1, hold2});
    bus.we = 1'b0;
    bus.re = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, ".rd"}, {bus.rd1, bus.rd2}, 64'd0);
    chk({tag, ".rvalid"}, 64'(bus.rvalid), 64'd0);
  endtask

  initial begin
    logic       r_we, r_re;
    logic [4:0] r_wa, r_a1, r_a2;

    rst_n = 1'b0;
    bus.we = 0; bus.waddr = 0; bus.wdata = 0; bus.re = 0; bus.ra1 = 0; bus.ra2 = 0;
    s_bus.we = 0; s_bus.waddr = 0; s_bus.wdata = 0; s_bus.re = 0; s_bus.ra1 = 0; s_bus.ra2 = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_cleared("reset_state");
    rst_n = 1'b1;

    cycle("rd_5_31", 0, 5'd0, 32'd0, 1, 5'd5, 5'd31);
    cycle("idle0", 0, 5'd0, 32'd0, 0, 5'd0, 5'd0);

    cycle("wr7", 1, 5'd7, 32'hDEADBEEF, 0, 5'd0, 5'd0);
    cycle("rd7", 0, 5'd0, 32'd0, 1, 5'd7, 5'd7);
    cycle("rd7_idle", 0, 5'd0, 32'd0, 0, 5'd7, 5'd7);

    cycle("wr0", 1, 5'd0, 32'h12345678, 0, 5'd0, 5'd0);
    cycle("rd0", 0, 5'd0, 32'd0, 1, 5'd0, 5'd7);

    cycle("wr3", 1, 5'd3, 32'h1, 0, 5'd0, 5'd0);
    cycle("rw3_same_edge", 1, 5'd3, 32'h2, 1, 5'd3, 5'd7);
    cycle("rd3_after", 0, 5'd0, 32'd0, 1, 5'd3, 5'd3);
    cycle("rw0_same_edge", 1, 5'd0, 32'hFFFF0000, 1, 5'd0, 5'd3);

    cycle("wr9", 1, 5'd9, 32'hA5A5A5A5, 0, 5'd0, 5'd0);
    cycle("rd9", 0, 5'd0, 32'd0, 1, 5'd9, 5'd9);
    rst_n = 1'b0;
    #1;
    check_cleared("async_reset");
    model_reset();
    rst_n = 1'b1;
    cycle("rd9_after_reset", 0, 5'd0, 32'd0, 1, 5'd9, 5'd3);

    // Hold reset across an edge with both enables asserted: nothing may happen.
    rst_n = 1'b0;
    bus.we = 1; bus.waddr = 5'd9; bus.wdata = 32'hCAFEF00D; bus.re = 1; bus.ra1 = 5'd9;
    @(posedge clk);
    #1;
    check_cleared("held_reset");
    bus.we = 0; bus.re = 0;
    rst_n = 1'b1;
    cycle("rd9_after_held", 0, 5'd0, 32'd0, 1, 5'd9, 5'd9);

    for (int i = 0; i < 60; i++) begin
      r_we = 1'($urandom_range(0, 1));
      r_re = ($urandom_range(0, 4) != 0);
      r_wa = 5'($urandom_range(0, 31));
      r_a1 = ($urandom_range(0, 3) == 0) ? r_wa : 5'($urandom_range(0, 31));
      r_a2 = ($urandom_range(0, 3) == 0) ? r_wa : 5'($urandom_range(0, 31));
      cycle("rand", r_we, r_wa, $urandom, r_re, r_a1, r_a2);
    end

    s_bus.we = 1; s_bus.waddr = 2'd3; s_bus.wdata = 8'hFF;
    @(posedge clk);
    #1;
    s_bus.we = 0; s_bus.re = 1; s_bus.ra1 = 2'd3; s_bus.ra2 = 2'd0;
    @(posedge clk);
    #1;
    chk("small.rd3", {48'd0, s_bus.rd1, s_bus.rd2}, 64'hFF00);
    chk("small.rvalid", 64'(s_bus.rvalid), 64'd1);
    s_bus.re = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("small.hold", 64'(s_bus.rd1), 64'hFF);
      chk("small.rvalid_low", 64'(s_bus.rvalid), 64'd0);
    end
    s_bus.we = 1; s_bus.waddr = 2'd0; s_bus.wdata = 8'h5A;
    @(posedge clk);
    #1;
    s_bus.we = 0; s_bus.re = 1; s_bus.ra1 = 2'd0; s_bus.ra2 = 2'd3;
    @(posedge clk);
    #1;
    chk("small.rd0", {48'd0, s_bus.rd1, s_bus.rd2}, 64'h5AFF);
    s_bus.re = 0;

    chk("sb.empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
